seg7_scan_reader: RTL and testbench

- Reader for a multiplexed, active-low 7-segment display bus (gfedcba segments plus per-digit anode enables).
- Samples the bus, waits for a stable pattern, and inverse-decodes it to a hex nibble per digit.
- Assembles one full frame of DIGITS nibbles and presents it through a valid/ready handshake.
- Sits beside the display path on the FPGA board, for self-check and readback of what the monociclo drives to the displays.

---
 rtl/seg7_scan_reader.sv | 185 ++++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
// Reads back a multiplexed, active-low 7-segment display bus. Each digit
// slot is sampled, must stay stable for STABLE_CYCLES samples, and is then
// inverse-decoded to a hex nibble. Once every digit has been seen, the
// assembled frame is offered through a valid/ready handshake.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   seg_i[6:0]     segment bus, active-low, bit6..0 = g,f,e,d,c,b,a
//   an_i[DIGITS-1:0] anode enables, active-low, an_i[i] selects digit i
//   frame_ready_i  consumer accepts the presented frame
//   frame_o        digit i nibble at [4i+3:4i]
//   blank_o        digit i was a blank pattern
//   frame_valid_o  frame_o/blank_o hold a complete frame
//   code_err_o     one-cycle pulse: stable but undecodable pattern
//   err_clr_i      (SEG7_SCAN_ERRCNT_EN only) clears err_count_o
//   err_count_o    (SEG7_SCAN_ERRCNT_EN only) saturating code_err_o count
//
// Optional feature macro: SEG7_SCAN_ERRCNT_EN (undefined by default).
module seg7_scan_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [6:0]            seg_i,
    input  logic [DIGITS-1:0]     an_i,
    input  logic                  frame_ready_i,
    output logic [4*DIGITS-1:0]   frame_o,
    output logic [DIGITS-1:0]     blank_o,
    output logic                  frame_valid_o,
`ifdef SEG7_SCAN_ERRCNT_EN
    input  logic                  err_clr_i,
    output logic [7:0]            err_count_o,
`endif
    output logic                  code_err_o
);

    typedef enum logic {COLLECT, PRESENT} state_t;

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

    state_t              state, state_n;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   an_q;
    logic [DIGITS+6:0]   prev_q;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DIGITS-1:0]   seen, seen_n;
    logic [DIGITS-1:0]   sel;
    logic [5:0]          dec;
    logic                sample_valid;
    logic                same;
    logic                commit;
    logic                commit_ok;
    logic                commit_bad;
    logic                wr_en;

    // True when exactly one anode line is low.
    function automatic logic one_low(input logic [DIGITS-1:0] an);
        int n;
        n = 0;
        for (int i = 0; i < DIGITS; i++)
            if (!an[i]) n = n + 1;
        return (n == 1);
    endfunction

    // Returns {decodable, blank, nibble}.
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = {2'b10, 4'h0};
            7'b1111001: decode = {2'b10, 4'h1};
            7'b0100100: decode = {2'b10, 4'h2};
            7'b0110000: decode = {2'b10, 4'h3};
            7'b0011001: decode = {2'b10, 4'h4};
            7'b0010010: decode = {2'b10, 4'h5};
            7'b0000010: decode = {2'b10, 4'h6};
            7'b1111000: decode = {2'b10, 4'h7};
            7'b0000000: decode = {2'b10, 4'h8};
            7'b0011000: decode = {2'b10, 4'h9};
            7'b0001000: decode = {2'b10, 4'hA};
            7'b0000011: decode = {2'b10, 4'hB};
            7'b1000110: decode = {2'b10, 4'hC};
            7'b0100001: decode = {2'b10, 4'hD};
            7'b0000110: decode = {2'b10, 4'hE};
            7'b0001110: decode = {2'b10, 4'hF};
            7'b1111111: decode = {2'b11, 4'h0};
            default:    decode = 6'b000000;
        endcase
    endfunction

    assign sample_valid = one_low(an_q);
    assign same         = ({an_q, seg_q} == prev_q);
    assign sel          = ~an_q;
    assign dec          = decode(seg_q);

    // Dwell counter: restarts on any change so a pattern sampled first at
    // edge k reaches STABLE at edge k+STABLE_CYCLES.
    always_comb begin
        cnt_n = '0;
        if (sample_valid) begin
            if (same)
                cnt_n = (cnt == STABLE) ? cnt : cnt + 1'b1;
            else
                cnt_n = CNT_W'(1);
        end
    end

    // Commit only on the transition into STABLE; saturation blocks re-commits.
    assign commit     = sample_valid && (cnt_n == STABLE) && (cnt != STABLE);
    assign commit_ok  = commit && dec[5];
    assign commit_bad = commit && !dec[5];

    always_comb begin
        state_n = state;
        seen_n  = seen;
        wr_en   = 1'b0;
        case (state)
            COLLECT: begin
                if (commit_ok) begin
                    wr_en  = 1'b1;
                    seen_n = seen | sel;
                    if (&seen_n) state_n = PRESENT;
                end
            end
            PRESENT: begin
                // A commit on the accepting edge starts the next frame.
                if (frame_ready_i) begin
                    wr_en   = commit_ok;
                    seen_n  = commit_ok ? sel : '0;
                    state_n = (&seen_n) ? PRESENT : COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= COLLECT;
        else         state <= state_n;
    end

    assign frame_valid_o = (state == PRESENT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_q      <= '1;
            an_q       <= '1;
            prev_q     <= '1;
            cnt        <= '0;
            seen       <= '0;
            frame_o    <= '0;
            blank_o    <= '0;
            code_err_o <= 1'b0;
        end else begin
            seg_q      <= seg_i;
            an_q       <= an_i;
            prev_q     <= {an_q, seg_q};
            cnt        <= cnt_n;
            seen       <= seen_n;
            code_err_o <= commit_bad;
            if (wr_en) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel[i]) begin
                        frame_o[4*i +: 4] <= dec[3:0];
                        blank_o[i]        <= dec[4];
                    end
                end
            end
        end
    end

`ifdef SEG7_SCAN_ERRCNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            err_count_o <= '0;
        else if (err_clr_i)
            err_count_o <= '0;
        else if (commit_bad && (err_count_o != 8'hFF))
            err_count_o <= err_count_o + 8'd1;
    end
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
module tb_seg7_scan_reader;
    localparam int DIGITS = 4;
    localparam int S      = 4;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        ready;
    logic [15:0] frame;
    logic [3:0]  blank;
    logic        fvalid;
    logic        cerr;
`ifdef SEG7_SCAN_ERRCNT_EN
    logic        err_clr;
    logic [7:0]  err_count;
    logic        clr_req;
    int          m_errcnt;
`endif

    always #5 clk = ~clk;

    seg7_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .seg_i(seg),
        .an_i(an),
        .frame_ready_i(ready),
        .frame_o(frame),
        .blank_o(blank),
        .frame_valid_o(fvalid),
`ifdef SEG7_SCAN_ERRCNT_EN
        .err_clr_i(err_clr),
        .err_count_o(err_count),
`endif
        .code_err_o(cerr)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Display encodings of 0..F, active-low gfedcba.
    logic [6:0] enc [0:15] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [3:0] IDLE  = 4'b1111;

    // Reference model: frame assembly state plus the last S+1 bus samples.
    logic [15:0] m_frame;
    logic [3:0]  m_blank;
    logic [3:0]  m_seen;
    logic        m_valid;
    logic        m_err;
    logic [10:0] hq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] anode(input int d);
        logic [3:0] a;
        a = '1;
        a[d] = 1'b0;
        return a;
    endfunction

    function automatic int low_count(input logic [3:0] a);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_frame = '0;
        m_blank = '0;
        m_seen  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
`ifdef SEG7_SCAN_ERRCNT_EN
        m_errcnt = 0;
`endif
        hq.delete();
        for (int i = 0; i <= S; i++) hq.push_back(11'h7FF);
    endtask

    // A digit commits at edge t when the samples taken at edges t-S..t-1 are
    // identical and single-anode, and the sample at edge t-S-1 was different.
    task automatic model_edge(input logic [10:0] smp, input logic r, input logic clr);
        logic       commit;
        logic       ok;
        logic       is_blank;
        logic [3:0] nib;
        int         d;
        commit = (low_count(hq[1][10:7]) == 1) && (hq[0] != hq[1]);
        for (int i = 2; i <= S; i++) if (hq[i] != hq[1]) commit = 1'b0;
        ok = 1'b0;
        is_blank = 1'b0;
        nib = 4'h0;
        if (hq[1][6:0] == BLANK) begin
            ok = 1'b1;
            is_blank = 1'b1;
        end
        for (int v = 0; v < 16; v++)
            if (enc[v] == hq[1][6:0]) begin
                ok = 1'b1;
                nib = 4'(v);
            end
        d = 0;
        for (int i = 0; i < 4; i++) if (!hq[1][7+i]) d = i;
        m_err = commit && !ok;
        if (m_valid && r) begin
            m_valid = 1'b0;
            m_seen  = '0;
        end
        if (commit && ok && !m_valid) begin
            m_frame[4*d +: 4] = nib;
            m_blank[d] = is_blank;
            m_seen[d] = 1'b1;
            if (m_seen == 4'hF) m_valid = 1'b1;
        end
`ifdef SEG7_SCAN_ERRCNT_EN
        if (clr) m_errcnt = 0;
        else if (m_err && m_errcnt < 255) m_errcnt++;
`else
        if (clr) m_err = m_err;
`endif
        hq.push_back(smp);
        void'(hq.pop_front());
    endtask

    task automatic cyc(input logic [3:0] a, input logic [6:0] s, input logic r);
        logic clr;
        an = a;
        seg = s;
        ready = r;
        clr = 1'b0;
`ifdef SEG7_SCAN_ERRCNT_EN
        err_clr = clr_req;
        clr = clr_req;
`endif
        @(posedge clk);
        model_edge({a, s}, r, clr);
        #1;
        chk("frame", 32'(frame), 32'(m_frame));
        chk("blank", 32'(blank), 32'(m_blank));
        chk("valid", 32'(fvalid), 32'(m_valid));
        chk("code_err", 32'(cerr), 32'(m_err));
`ifdef SEG7_SCAN_ERRCNT_EN
        chk("err_count", 32'(err_count), 32'(m_errcnt));
`endif
    endtask

    task automatic dwell(input int d, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) cyc(anode(d), s, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_frame"}, 32'(frame), 32'h0);
        chk({tag, "_blank"}, 32'(blank), 32'h0);
        chk({tag, "_valid"}, 32'(fvalid), 32'h0);
        chk({tag, "_err"}, 32'(cerr), 32'h0);
    endtask

    initial begin
        int pulses;
        int d;
        int len;
        int kind;
        logic [3:0] a;
        logic [6:0] s;

        rst_ni = 1'b0;
        an = IDLE;
        seg = BLANK;
        ready = 1'b0;
`ifdef SEG7_SCAN_ERRCNT_EN
        err_clr = 1'b0;
        clr_req = 1'b0;
`endif
        model_reset();
        #12;
        check_all_zero("reset");
        rst_ni = 1'b1;
        cyc(IDLE, BLANK, 1'b0);

        // Scan 1,A,2,F on digits 3..0; frame appears at the digit 0 commit.
        dwell(3, enc[1], 8);
        dwell(2, enc[10], 8);
        dwell(1, enc[2], 8);
        dwell(0, enc[15], S);
        chk("t1_valid_before", 32'(fvalid), 32'h0);
        cyc(anode(0), enc[15], 1'b0);
        chk("t1_valid_rise", 32'(fvalid), 32'h1);
        dwell(0, enc[15], 3);
        chk("t1_frame", 32'(frame), 32'h1A2F);
        chk("t1_blank", 32'(blank), 32'h0);

        // Commits while presenting are ignored.
        dwell(3, enc[5], 6);
        chk("t1_hold_frame", 32'(frame), 32'h1A2F);
        chk("t1_hold_valid", 32'(fvalid), 32'h1);

        // Accept on the same edge as a digit 0 commit of 7.
        dwell(0, enc[7], S);
        cyc(anode(0), enc[7], 1'b1);
        chk("t5_valid_fall", 32'(fvalid), 32'h0);
        chk("t5_nib0", 32'(frame[3:0]), 32'h7);
        dwell(0, enc[7], 2);

        // Dwell of S-1 cycles on digit 2 must not commit.
        dwell(2, enc[3], S - 1);

        // Undecodable pattern on digit 1: exactly one error pulse.
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(anode(1), 7'b0101010, 1'b0);
            if (cerr) pulses++;
        end
        chk("t3_pulses", 32'(pulses), 32'h1);
        chk("t3_nib1", 32'(frame[7:4]), 32'h2);
`ifdef SEG7_SCAN_ERRCNT_EN
        chk("t3_errcnt", 32'(err_count), 32'h1);
`endif

        // Digits 1 and 3 commit; digit 2 is still missing.
        dwell(1, enc[4], 6);
        dwell(3, enc[9], 6);
        chk("t2_valid_no_frame", 32'(fvalid), 32'h0);

        // Two anodes low: no commit, no error.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(4'b1100, enc[8], 1'b0);
            if (cerr) pulses++;
        end
        chk("t4_pulses", 32'(pulses), 32'h0);
        chk("t4_valid", 32'(fvalid), 32'h0);
        dwell(2, enc[3], 6);
        chk("t4_valid", 32'(fvalid), 32'h1);
        chk("t4_frame", 32'(frame), 32'h9347);
        cyc(IDLE, BLANK, 1'b1);
        chk("t4_accept", 32'(fvalid), 32'h0);

        // Reset after two commits; a full rescan is needed afterwards.
        dwell(3, enc[14], 6);
        dwell(2, BLANK, 6);
        rst_ni = 1'b0;
        #2;
        check_all_zero("t6_async");
        model_reset();
        @(posedge clk);
        #3;
        rst_ni = 1'b1;
        dwell(1, enc[5], 6);
        dwell(0, enc[6], 6);
        chk("t6_partial_valid", 32'(fvalid), 32'h0);
        dwell(3, enc[12], 6);
        dwell(2, BLANK, 6);
        chk("t6_valid", 32'(fvalid), 32'h1);
        chk("t6_frame", 32'(frame), 32'hC056);
        chk("t6_blank", 32'(blank), 32'h4);
        cyc(IDLE, BLANK, 1'b1);

        // Randomized scanning against the reference model.
        for (int it = 0; it < 300; it++) begin
            d = $urandom_range(0, 3);
            len = $urandom_range(1, 9);
            kind = $urandom_range(0, 9);
            a = anode(d);
            s = enc[$urandom_range(0, 15)];
            if (kind == 7) s = BLANK;
            if (kind == 8) s = 7'($urandom);
            if (kind == 9) a = 4'($urandom);
            for (int i = 0; i < len; i++) begin
`ifdef SEG7_SCAN_ERRCNT_EN
                clr_req = ($urandom_range(0, 30) == 0);
`endif
                cyc(a, s, ($urandom_range(0, 2) == 0));
            end
        end
`ifdef SEG7_SCAN_ERRCNT_EN
        clr_req = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
